// File: rtl/fetch_queue.sv
// Instruction-fetch front end: credit-limited in-order word fetch, PC-tagged FIFO to decode,
// redirect flush with stale-response discard. Optional FETCH_MISALIGN_CHECK_EN adds a sticky misalign fault.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   fifo_instr [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, outstanding, discard;
  logic [31:0]   fetch_pc, resp_pc, redir_al;
  logic [CW:0]   in_use;
  logic          fault, grant, resp, push, pop;

  assign redir_al = {redirect_pc[31:2], 2'b00};
  // FIFO slots plus in-flight requests never exceed DEPTH, so a push always has room.
  assign in_use   = {1'b0, count} + {1'b0, outstanding};
  assign imem_req = !reset && !redirect_valid && !fault && (in_use < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;

  assign grant = imem_req && imem_gnt;
  assign resp  = imem_rvalid && (outstanding != '0);
  assign push  = resp && !redirect_valid && (discard == '0);

  assign dec_valid = (count != '0) && !redirect_valid;
  assign dec_instr = fifo_instr[rd_ptr];
  assign dec_pc    = fifo_pc[rd_ptr];
  assign pop       = dec_valid && dec_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(resp);
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old stream.
        count    <= '0;
        rd_ptr   <= wr_ptr;
        fetch_pc <= redir_al;
        resp_pc  <= redir_al;
        discard  <= outstanding - CW'(resp);
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (resp && discard != '0) discard <= discard - CW'(1);
        if (push) begin
          fifo_pc[wr_ptr]    <= resp_pc;
          fifo_instr[wr_ptr] <= imem_rdata;
          wr_ptr             <= wr_ptr + AW'(1);
          resp_pc            <= resp_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               fault <= 1'b0;
    else if (redirect_valid) fault <= |redirect_pc[1:0];
  end
`else
  logic unused_lsbs;
  assign unused_lsbs = ^redirect_pc[1:0];
  assign fault = 1'b0;
`endif

  assign fetch_fault = fault;
endmodule
